// File: rtl/load_queue_pkg.sv
// Shared types for the load queue and its neighbours in the load-store unit.
//   id_t          : instruction id carried with each load
//   lq_entry_t    : one pending load (addr, byte enables, funct3, float flag, id)
//   cpu_config_t  : core configuration; the LSU passes CONFIG.LQ_DEPTH and
//                   CONFIG.SQ_DEPTH into load_queue
package load_queue_pkg;

  localparam int ID_W = 4;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [2:0]  fn3;
    logic        is_float;
    id_t         id;
  } lq_entry_t;

  typedef struct packed {
    int unsigned LQ_DEPTH;
    int unsigned SQ_DEPTH;
  } cpu_config_t;

  localparam cpu_config_t DEFAULT_CONFIG = '{LQ_DEPTH: 32'd4, SQ_DEPTH: 32'd4};

endpackage

// File: rtl/load_queue_if.sv
// Handshake bundle between the load-store unit / store queue and the load queue.
//   master : drives push, data_in, potential_store_conflicts, store_conflict,
//            issue_ready; observes everything else
//   slave  : the load queue itself
interface load_queue_if
  import load_queue_pkg::*;
#(
  parameter int SQ_DEPTH = 4
) ();

  logic                push;
  lq_entry_t           data_in;
  logic [SQ_DEPTH-1:0] potential_store_conflicts;
  logic                full;
  logic                empty;
  logic                lq_push;
  logic [SQ_DEPTH-1:0] prev_store_conflicts;
  logic                store_conflict;
  logic                issue_ready;
  logic                issue_valid;
  logic                lq_pop;
  lq_entry_t           data_out;

  modport master (
    output push, data_in, potential_store_conflicts, store_conflict, issue_ready,
    input  full, empty, lq_push, prev_store_conflicts, issue_valid, lq_pop, data_out
  );

  modport slave (
    input  push, data_in, potential_store_conflicts, store_conflict, issue_ready,
    output full, empty, lq_push, prev_store_conflicts, issue_valid, lq_pop, data_out
  );

endinterface

// File: rtl/load_queue_lq_ptr_counter.sv
// Read/write pointers, occupancy count and registered full flag of the load queue.
//   clk, rst      : clock, asynchronous active-low reset
//   push_i, pop_i : accepted push / pop strobes for this cycle
//   wr_ptr_o      : slot written by the next accepted push
//   rd_ptr_o      : head slot
//   count_o       : number of valid entries
//   full_o        : registered, set when the next-cycle count equals LQ_DEPTH
module lq_ptr_counter #(
  parameter int LQ_DEPTH = 4,
  parameter int PTR_W    = $clog2(LQ_DEPTH),
  parameter int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  // Next-state: pointers wrap naturally because LQ_DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
    full_d  = (count_d == CNT_W'(LQ_DEPTH));
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full_q;

endmodule

// File: rtl/load_queue.sv
// In-order FIFO of pending loads. Each load is stored with the store-queue
// conflict mask sampled at push; the head is offered to the data port once the
// store queue reports no outstanding conflict.
//   clk, rst : clock, asynchronous active-low reset
//   lq       : load_queue_if.slave (push side, issue side, store-queue strobes)
module load_queue
  import load_queue_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int SQ_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  load_queue_if.slave lq
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lq_entry_t           entries_q [LQ_DEPTH];
  logic [SQ_DEPTH-1:0] masks_q   [LQ_DEPTH];

  logic [PTR_W-1:0]    wr_ptr_s;
  logic [PTR_W-1:0]    rd_ptr_s;
  logic [CNT_W-1:0]    count_s;
  logic                full_s;
  logic                empty_s;
  logic                lq_push_s;
  logic                issue_valid_s;
  logic                lq_pop_s;
  logic [SQ_DEPTH-1:0] prev_mask_s;

  lq_ptr_counter #(
    .LQ_DEPTH (LQ_DEPTH),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .push_i   (lq_push_s),
    .pop_i    (lq_pop_s),
    .wr_ptr_o (wr_ptr_s),
    .rd_ptr_o (rd_ptr_s),
    .count_o  (count_s),
    .full_o   (full_s)
  );

  // Accept/issue strobes. A push while full is refused even if the head pops
  // this cycle: full is registered, so the freed slot only opens next cycle.
  // The rst term keeps lq_push low while reset is held.
  always_comb begin
    empty_s       = (count_s == {CNT_W{1'b0}});
    lq_push_s     = rst & lq.push & ~full_s;
    issue_valid_s = ~empty_s & ~lq.store_conflict;
    lq_pop_s      = issue_valid_s & lq.issue_ready;
  end

  // Head mask read; a popped slot keeps its stale mask, so hide it when empty
  always_comb begin
    if (empty_s) begin
      prev_mask_s = {SQ_DEPTH{1'b0}};
    end else begin
      prev_mask_s = masks_q[rd_ptr_s];
    end
  end

  // Entry storage is deliberately not reset; validity comes from count alone
  always_ff @(posedge clk) begin
    if (lq_push_s) begin
      entries_q[wr_ptr_s] <= lq.data_in;
      masks_q[wr_ptr_s]   <= lq.potential_store_conflicts;
    end
  end

  assign lq.full                 = full_s;
  assign lq.empty                = empty_s;
  assign lq.lq_push              = lq_push_s;
  assign lq.issue_valid          = issue_valid_s;
  assign lq.lq_pop               = lq_pop_s;
  assign lq.prev_store_conflicts = prev_mask_s;
  assign lq.data_out             = entries_q[rd_ptr_s];

  // Overflow: a push arriving while full must never be accepted
  a_overflow : assert property (@(posedge clk) disable iff (!rst)
    lq.full |-> !lq.lq_push);

  // Pushes into a full queue are legal traffic that gets dropped
  c_overflow_attempt : cover property (@(posedge clk) disable iff (!rst)
    lq.push && lq.full);

  // Underflow: no pop may happen without a valid head
  a_underflow : assert property (@(posedge clk) disable iff (!rst)
    !(lq.lq_pop && lq.empty));

endmodule

// File: tb/tb_load_queue.sv
module tb_load_queue;
  import load_queue_pkg::*;

  localparam int LQ_D = 4;
  localparam int SQ_D = 4;

  typedef struct packed {
    lq_entry_t        e;
    logic [SQ_D-1:0]  m;
  } slot_t;

  logic clk;
  logic rst;

  load_queue_if #(.SQ_DEPTH(SQ_D)) lqi ();

  load_queue #(.LQ_DEPTH(LQ_D), .SQ_DEPTH(SQ_D)) dut (
    .clk (clk),
    .rst (rst),
    .lq  (lqi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of accepted loads plus a full flag that
  // follows the occupancy left after each clock edge.
  slot_t mq[$];
  bit    m_full;

  int checks;
  int failures;

  bit        last_pop;
  bit        last_iv;
  bit        last_lq_push;
  id_t       last_id;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic lq_entry_t mk_entry(input logic [31:0] addr, input id_t id);
    lq_entry_t e;
    e.addr     = addr;
    e.be       = 4'($urandom_range(15, 0));
    e.fn3      = 3'($urandom_range(7, 0));
    e.is_float = 1'($urandom_range(1, 0));
    e.id       = id;
    return e;
  endfunction

  // One clock: drive at negedge, compare 1 time unit later, advance model at posedge
  task automatic step(input bit r, input bit p, input lq_entry_t d, input logic [SQ_D-1:0] m,
                      input bit sc, input bit rdy);
    bit             e_empty;
    bit             e_push;
    bit             e_iv;
    bit             e_pop;
    logic [SQ_D-1:0] e_psc;
    @(negedge clk);
    rst                            = r;
    lqi.push                       = p;
    lqi.data_in                    = d;
    lqi.potential_store_conflicts  = m;
    lqi.store_conflict             = sc;
    lqi.issue_ready                = rdy;
    if (!r) begin
      mq.delete();
      m_full = 1'b0;
    end
    e_empty = (mq.size() == 0);
    e_push  = r && p && !m_full;
    e_iv    = r && !e_empty && !sc;
    e_pop   = e_iv && rdy;
    e_psc   = e_empty ? {SQ_D{1'b0}} : mq[0].m;
    #1;
    check_eq("empty", 64'(lqi.empty), 64'(e_empty));
    check_eq("full", 64'(lqi.full), 64'(m_full));
    check_eq("lq_push", 64'(lqi.lq_push), 64'(e_push));
    check_eq("issue_valid", 64'(lqi.issue_valid), 64'(e_iv));
    check_eq("lq_pop", 64'(lqi.lq_pop), 64'(e_pop));
    check_eq("prev_store_conflicts", 64'(lqi.prev_store_conflicts), 64'(e_psc));
    if (!e_empty) begin
      check_eq("data_out", 64'(lqi.data_out), 64'(mq[0].e));
    end
    last_pop     = lqi.lq_pop;
    last_iv      = lqi.issue_valid;
    last_lq_push = lqi.lq_push;
    last_id      = lqi.data_out.id;
    @(posedge clk);
    if (r) begin
      if (e_pop) begin
        void'(mq.pop_front());
      end
      if (e_push) begin
        mq.push_back('{e: d, m: m});
      end
      m_full = (mq.size() == LQ_D);
    end
  endtask

  task automatic idle(input bit sc, input bit rdy);
    step(1'b1, 1'b0, mk_entry(32'h0, 4'd0), 4'b0000, sc, rdy);
  endtask

  initial begin
    int exp_id;
    checks   = 0;
    failures = 0;
    m_full   = 1'b0;
    rst      = 1'b0;
    lqi.push = 1'b0;
    lqi.data_in = '0;
    lqi.potential_store_conflicts = 4'b0000;
    lqi.store_conflict = 1'b0;
    lqi.issue_ready = 1'b0;

    // Reset state, with a push and a ready port presented during reset
    step(1'b0, 1'b1, mk_entry(32'h55, 4'd1), 4'b1111, 1'b0, 1'b1);
    step(1'b0, 1'b0, mk_entry(32'h0, 4'd0), 4'b0000, 1'b0, 1'b1);

    // Single load, issued the cycle after it is pushed
    step(1'b1, 1'b1, mk_entry(32'h100, 4'd3), 4'b0010, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check_eq("t1_issue_pop", 64'(last_pop), 64'd1);
    check_eq("t1_head_id", 64'(last_id), 64'd3);
    idle(1'b0, 1'b1);

    // Fill to four, then a fifth push is dropped
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, mk_entry(32'h200 + 32'(i), id_t'(i)), 4'(i), 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, mk_entry(32'h300, 4'd9), 4'b1000, 1'b0, 1'b0);
    check_eq("t2_overflow_drop", 64'(last_lq_push), 64'd0);
    // Pop and push together at full: push refused, accepted next cycle
    step(1'b1, 1'b1, mk_entry(32'h400, 4'd10), 4'b0100, 1'b0, 1'b1);
    check_eq("t3_same_cycle_refused", 64'(last_lq_push), 64'd0);
    step(1'b1, 1'b1, mk_entry(32'h404, 4'd11), 4'b0100, 1'b0, 1'b0);
    check_eq("t3_next_cycle_accepted", 64'(last_lq_push), 64'd1);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b1);

    // Head held back by a store conflict for three cycles
    step(1'b1, 1'b1, mk_entry(32'h500, 4'd5), 4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      check_eq("t4_conflict_hold", 64'(last_iv), 64'd0);
    end
    idle(1'b0, 1'b1);
    check_eq("t4_release_pop", 64'(last_pop), 64'd1);
    idle(1'b0, 1'b1);

    // Continuous push/pop across pointer wrap; ids must come out 0..9
    exp_id = 0;
    for (int k = 0; k <= 10; k++) begin
      step(1'b1, k < 10, mk_entry(32'h1000 + 32'(k), id_t'(k)), 4'(k), 1'b0, 1'b1);
      if (last_pop) begin
        check_eq("t5_wrap_id", 64'(last_id), 64'(exp_id));
        exp_id++;
      end
      check_eq("t5_never_full", 64'(lqi.full), 64'd0);
    end
    check_eq("t5_wrap_total", 64'(exp_id), 64'd10);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, mk_entry(32'h600 + 32'(i), id_t'(i)), 4'b0011, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, mk_entry(32'h700, 4'd7), 4'b0011, 1'b0, 1'b1);
    step(1'b1, 1'b0, mk_entry(32'h0, 4'd0), 4'b0000, 1'b0, 1'b1);
    check_eq("t6_no_pop_after_reset", 64'(last_pop), 64'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(99, 0) != 0),
           ($urandom_range(9, 0) < 6),
           mk_entry($urandom, id_t'($urandom_range(15, 0))),
           4'($urandom_range(15, 0)),
           ($urandom_range(3, 0) == 0),
           ($urandom_range(9, 0) < 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
